// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer
//   Transmit-side serializer for the WM8731 CODEC. Stereo pairs are pushed
//   through a write/write_ready handshake into a small FIFO. They are shifted
//   out MSB-first, left-justified, on AUD_DACDAT. The bit and frame clocks are
//   mastered by the CODEC.
//
// Ports
//   CLOCK_50         in   system clock, all state on its rising edge
//   reset_n          in   asynchronous active-low reset
//   write            in   push request, accepted when write && write_ready
//   writedata_left   in   left sample, two's complement
//   writedata_right  in   right sample, two's complement
//   write_ready      out  FIFO not full
//   fifo_used        out  pairs currently buffered
//   underflow        out  one-cycle pulse when a frame starts with no data
//   AUD_BCLK         in   CODEC bit clock (asynchronous)
//   AUD_DACLRCK      in   CODEC frame clock, high = left slot
//   AUD_DACDAT       out  serial DAC data
//
// state | meaning
// ------+---------------------------------------------------------
// ALIGN | waiting for the first frame start, output held at 0
// LEFT  | shifting the left sample (AUD_DACLRCK high)
// RIGHT | shifting the right sample (AUD_DACLRCK low)

module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          write,
  input  logic [DATA_WIDTH-1:0]         writedata_left,
  input  logic [DATA_WIDTH-1:0]         writedata_right,
  output logic                          write_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_used,
  output logic                          underflow,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

  state_t state;

  logic bclk_meta, bclk_sync, bclk_prev;
  logic lrck_meta, lrck_sync, lrck_prev;
  logic bclk_fall, lrck_rise, lrck_fall;

  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic                    fifo_empty;
  logic                    push, pop;
  logic [DATA_WIDTH-1:0]   head_left, head_right;

  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   hold_r;
  logic [BIT_W-1:0]        bit_cnt;

  // Two-stage synchronizers followed by a registered edge detector.
  // The strobes are one CLOCK_50 cycle wide.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_meta <= 1'b0;
      bclk_sync <= 1'b0;
      bclk_prev <= 1'b0;
      lrck_meta <= 1'b0;
      lrck_sync <= 1'b0;
      lrck_prev <= 1'b0;
      bclk_fall <= 1'b0;
      lrck_rise <= 1'b0;
      lrck_fall <= 1'b0;
    end else begin
      bclk_meta <= AUD_BCLK;
      bclk_sync <= bclk_meta;
      bclk_prev <= bclk_sync;
      lrck_meta <= AUD_DACLRCK;
      lrck_sync <= lrck_meta;
      lrck_prev <= lrck_sync;
      bclk_fall <= bclk_prev & ~bclk_sync;
      lrck_rise <= ~lrck_prev & lrck_sync;
      lrck_fall <= lrck_prev & ~lrck_sync;
    end
  end

  assign fifo_empty  = (fifo_used == '0);
  assign write_ready = (fifo_used != CNT_W'(FIFO_DEPTH));
  assign push        = write & write_ready;
  assign pop         = lrck_rise & ~fifo_empty;
  assign head_left   = mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
  assign head_right  = mem[rd_ptr][DATA_WIDTH-1:0];

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {writedata_left, writedata_right};
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_used <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_used <= fifo_used + 1'b1;
        2'b01:   fifo_used <= fifo_used - 1'b1;
        default: fifo_used <= fifo_used;
      endcase
    end
  end

  // Frame edges take priority over a coincident bclk_fall. When LRCK changes on
  // a BCLK falling edge, both strobes arrive together and the edge reloads the
  // shifter.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ALIGN;
      shift_reg  <= '0;
      hold_r     <= '0;
      bit_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (lrck_rise) begin
        state   <= LEFT;
        bit_cnt <= BIT_W'(1);
        if (!fifo_empty) begin
          shift_reg  <= head_left;
          hold_r     <= head_right;
          AUD_DACDAT <= head_left[DATA_WIDTH-1];
        end else begin
          shift_reg  <= '0;
          hold_r     <= '0;
          AUD_DACDAT <= 1'b0;
          underflow  <= 1'b1;
        end
      end else if (lrck_fall && state == LEFT) begin
        state      <= RIGHT;
        shift_reg  <= hold_r;
        AUD_DACDAT <= hold_r[DATA_WIDTH-1];
        bit_cnt    <= BIT_W'(1);
      end else if (bclk_fall && state != ALIGN) begin
        if (bit_cnt < BIT_W'(DATA_WIDTH)) begin
          shift_reg  <= shift_reg << 1;
          AUD_DACDAT <= shift_reg[DATA_WIDTH-2];
          bit_cnt    <= bit_cnt + 1'b1;
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Transmit-side serializer for the WM8731 audio CODEC on the DE1-SoC. It accepts stereo sample pairs over the same read/write ready handshake the filter datapath already uses, and buffers them in a small FIFO. It then shifts each pair out MSB-first on AUD_DACDAT in left-justified format, slaved to the CODEC-mastered AUD_BCLK and AUD_DACLRCK. It sits between the filter output mux and the AUD_DACDAT pin, replacing the DAC half of the vendor codec core.

## Interface
Parameters:
- DATA_WIDTH, 24, bits per channel sample.
- FIFO_DEPTH, 8, stereo pairs buffered; power of two, ≥2.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz; all state on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- write  input  1  push request; a pair is accepted when write && write_ready.
- writedata_left  input  DATA_WIDTH  left sample, two's complement.
- writedata_right  input  DATA_WIDTH  right sample, two's complement.
- write_ready  output  1  high when the FIFO is not full.
- fifo_used  output  $clog2(FIFO_DEPTH)+1  number of pairs currently in the FIFO.
- underflow  output  1  one-cycle pulse when a frame starts with the FIFO empty.
- AUD_BCLK  input  1  CODEC bit clock, asynchronous to CLOCK_50.
- AUD_DACLRCK  input  1  CODEC frame clock: high = left, low = right.
- AUD_DACDAT  output  1  serial DAC data.

## Operation
- AUD_BCLK and AUD_DACLRCK each pass through a 2-FF synchronizer, then a registered edge detector. This produces bclk_fall, lrck_rise and lrck_fall strobes, one CLOCK_50 cycle wide.
- FIFO: a circular buffer of {left,right} pairs with wrap-around read and write pointers. A push is ignored when full, because write_ready=0 then. A pop happens only at lrck_rise.
- Simultaneous push and pop in one cycle: both take effect and fifo_used is unchanged.
- Frame start: lrck_rise selects one of two cases.
  - FIFO non-empty: pop the head; load left into the shift register and latch right into hold_r.
  - FIFO empty: load zeros into both, and pulse underflow for one cycle. A push in the same cycle is stored but not used until the next frame.
- lrck_fall: load hold_r into the shift register.
- Any LRCK edge drives shift-register MSB onto AUD_DACDAT on the next cycle and sets bit_cnt=1.
- bclk_fall with bit_cnt < DATA_WIDTH: shift left by one, drive the new MSB, and increment bit_cnt.
- bclk_fall with bit_cnt == DATA_WIDTH: drive 0 until the next LRCK edge.
- An LRCK edge and bclk_fall in the same cycle: the LRCK edge wins and bclk_fall is ignored.
- State machine:
  - ALIGN (after reset): AUD_DACDAT=0, no pops. Go to LEFT on the first lrck_rise.
  - LEFT: go to RIGHT on lrck_fall.
  - RIGHT: go to LEFT on lrck_rise.
  - The serializer never starts mid-frame.
- Reset, asynchronous and mid-operation: FIFO empties, pointers go to 0, shift register and hold_r go to 0, state returns to ALIGN, and the synchronizers clear.

## Timing
- Reset values: write_ready=1, fifo_used=0, underflow=0, AUD_DACDAT=0.
- write_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees a slot.
- fifo_used updates one cycle after the push or pop.
- Pin-to-output latency: an AUD_DACLRCK or AUD_BCLK pin edge reaches AUD_DACDAT in 4 CLOCK_50 cycles (2 synchronizer + 1 edge detect + 1 output register), i.e. 80 ns.
- This latency requires an AUD_BCLK half-period ≥ 5 CLOCK_50 cycles. The DE1 rate of 3.072 MHz (≈163 ns half-period) meets it. The CODEC samples on the BCLK rising edge.
- Each channel slot carries exactly DATA_WIDTH bits; trailing BCLKs output 0.
- underflow pulses at most once per frame.

## Test plan
- Reset, then ALIGN: hold reset_n low mid-frame, release, and toggle AUD_DACLRCK starting low. Required: AUD_DACDAT=0 and no pop until the first lrck_rise; write_ready=1, fifo_used=0.
- Single frame: push L=24'hA5F00F, R=24'h123456, then run a 64-BCLK frame (48 kHz). Required: 24 bits A5F00F MSB-first in the high half and 123456 in the low half, zeros after bit 24; fifo_used goes 1→0 at lrck_rise.
- Full FIFO: push 9 pairs back-to-back with write=1. Required: write_ready=0 after the 8th push, the 9th is ignored, fifo_used=8, and the first 8 pairs are serialized in order across 8 frames.
- Underflow: 3 frames with an empty FIFO. Required: an underflow pulse at each lrck_rise and AUD_DACDAT=0 throughout.
- Simultaneous push and pop: assert write in the exact lrck_rise cycle with fifo_used=1. Required: fifo_used stays 1, the old pair is serialized, and the new pair goes out next frame.
- Wrap-around: stream 20 pairs at the frame rate (counting pattern 1..20). Required: output matches 1..20 across pointer wrap, with no underflow once primed.
